// File: rtl/muldiv_pkg.sv
// Shared types and op-decoding helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_signed_a(input md_op_e op);
    return op inside {MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic is_signed_b(input md_op_e op);
    return op inside {MULH, DIV, REM};
  endfunction

  function automatic logic is_div(input md_op_e op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic is_high(input md_op_e op);
    return op inside {MULH, MULHSU, MULHU};
  endfunction

  function automatic logic is_rem(input md_op_e op);
    return op inside {REM, REMU};
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Operand/result bundle between the execute stage and the multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  // Both channels transfer on a cycle where valid && ready; the producer holds its
  // payload stable while valid is high and ready is low.
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       MD_Operation;
  logic [WIDTH-1:0] Data1;
  logic [WIDTH-1:0] Data2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] MD_result;
  logic             ZERO;

  modport master (
    output in_valid, MD_Operation, Data1, Data2, out_ready,
    input  in_ready, out_valid, MD_result, ZERO
  );

  modport slave (
    input  in_valid, MD_Operation, Data1, Data2, out_ready,
    output in_ready, out_valid, MD_result, ZERO
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opd,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  // Multiply: {hi,lo} is the running product, lo's LSB selects the add.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, opd};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        hi_n = diff[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = shifted[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle on unsigned
// magnitudes, sign fix-up on the last step, RISC-V results for /0 and overflow.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  muldiv_if.slave md,
  output state_e  dbg_state
);
  localparam int               CNT_W   = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  md_op_e             op_q, op_n, op_in;
  logic               sa_q, sa_n, sb_q, sb_n, sa_in, sb_in;
  logic [WIDTH-1:0]   hi, hi_n, lo, lo_n, opd, opd_n, res, res_n;
  logic [WIDTH-1:0]   a_mag, b_mag, step_hi, step_lo;
  logic [WIDTH-1:0]   quo_s, rem_s, final_res;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic               accept;

  assign md.in_ready  = (state == IDLE) && !flush;
  assign md.out_valid = (state == DONE);
  assign md.MD_result = res;
  assign md.ZERO      = (state == DONE) && (res == '0);
  assign dbg_state    = state;

  assign accept = md.in_valid && md.in_ready;
  assign op_in  = md_op_e'(md.MD_Operation);
  assign sa_in  = is_signed_a(op_in) && md.Data1[WIDTH-1];
  assign sb_in  = is_signed_b(op_in) && md.Data2[WIDTH-1];
  // The most-negative value negates to itself, which is its correct unsigned magnitude.
  assign a_mag  = sa_in ? -md.Data1 : md.Data1;
  assign b_mag  = sb_in ? -md.Data2 : md.Data2;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div(op_q)),
    .hi     (hi),
    .lo     (lo),
    .opd    (opd),
    .hi_n   (step_hi),
    .lo_n   (step_lo)
  );

  assign prod   = {step_hi, step_lo};
  assign prod_s = (sa_q ^ sb_q) ? -prod : prod;
  assign quo_s  = (sa_q ^ sb_q) ? -step_lo : step_lo;
  assign rem_s  = sa_q ? -step_hi : step_hi;

  always_comb begin
    if (is_div(op_q)) final_res = is_rem(op_q) ? rem_s : quo_s;
    else              final_res = is_high(op_q) ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= MUL;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      opd   <= '0;
      res   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      op_q  <= op_n;
      sa_q  <= sa_n;
      sb_q  <= sb_n;
      hi    <= hi_n;
      lo    <= lo_n;
      opd   <= opd_n;
      res   <= res_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    sa_n    = sa_q;
    sb_n    = sb_q;
    hi_n    = hi;
    lo_n    = lo;
    opd_n   = opd;
    res_n   = res;
    case (state)
      IDLE: begin
        if (accept) begin
          op_n  = op_in;
          sa_n  = sa_in;
          sb_n  = sb_in;
          hi_n  = '0;
          cnt_n = CNT_W'(WIDTH);
          lo_n  = is_div(op_in) ? a_mag : b_mag;
          opd_n = is_div(op_in) ? b_mag : a_mag;
          if (is_div(op_in) && (md.Data2 == '0)) begin
            res_n   = is_rem(op_in) ? md.Data1 : '1;
            state_n = DONE;
          end else if (is_div(op_in) && is_signed_a(op_in) &&
                       (md.Data1 == MIN_NEG) && (md.Data2 == '1)) begin
            res_n   = is_rem(op_in) ? '0 : md.Data1;
            state_n = DONE;
          end else begin
            state_n = CALC;
          end
        end
      end
      CALC: begin
        hi_n  = step_hi;
        lo_n  = step_lo;
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          res_n   = final_res;
          state_n = DONE;
        end
      end
      DONE: begin
        if (md.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: cycle-level behavioural model with expected-result queue,
// directed corner cases with literal results, then randomized traffic with backpressure/flush.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int          W   = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;

  logic   clk;
  logic   rst_n;
  logic   flush;
  state_e dbg_state;

  muldiv_if #(.WIDTH(W)) md ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .md        (md),
    .dbg_state (dbg_state)
  );

  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  bit           rnd_mode = 0;
  logic [W-1:0] exp_q[$];
  int           due_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog sim_time_limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    ua = {{W{1'b0}}, a};
    ub = {{W{1'b0}}, b};
    ia = a;
    ib = b;
    p  = '0;
    model = '0;
    case (op)
      3'd0: begin p = ua * ub; model = p[W-1:0]; end
      3'd1: begin p = sa * sb; model = p[2*W-1:W]; end
      3'd2: begin p = sa * ub; model = p[2*W-1:W]; end
      3'd3: begin p = ua * ub; model = p[2*W-1:W]; end
      3'd4: model = (b == '0) ? '1 : ((a == MIN && b == '1) ? a : W'(ia / ib));
      3'd5: model = (b == '0) ? '1 : a / b;
      3'd6: model = (b == '0) ? a : ((a == MIN && b == '1) ? '0 : W'(ia % ib));
      default: model = (b == '0) ? a : a % b;
    endcase
  endfunction

  function automatic bit special(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    return op[2] && ((b == '0) || (!op[0] && a == MIN && b == '1));
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] s;
    s = W'($urandom_range(0, 15));
    case ($urandom_range(0, 7))
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return MIN;
      4: return s;
      5: return -s;
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout", name);
  endtask

  // ---------------- scoreboard / compare process ----------------
  initial begin
    logic exp_rdy, exp_vld;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        due_q.delete();
      end else begin
        exp_rdy = (exp_q.size() == 0) && !flush;
        exp_vld = (exp_q.size() != 0) && (cyc >= due_q[0]);
        chk("in_ready", md.in_ready, exp_rdy);
        chk("out_valid", md.out_valid, exp_vld);
        if (exp_vld) begin
          chk("md_result", md.MD_result, exp_q[0]);
          chk("zero", md.ZERO, exp_q[0] == '0);
        end
        if (flush) begin
          exp_q.delete();
          due_q.delete();
        end else if (exp_vld && md.out_ready) begin
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end else if (md.in_valid && exp_rdy) begin
          exp_q.push_back(model(md.MD_Operation, md.Data1, md.Data2));
          due_q.push_back(cyc + 1 +
                          (special(md.MD_Operation, md.Data1, md.Data2) ? 0 : W));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit done;
    done = 0;
    md.in_valid     = 1'b1;
    md.MD_Operation = op;
    md.Data1        = a;
    md.Data2        = b;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      done = md.in_ready && !flush;
      @(posedge clk);
      #1;
      if (rnd_mode) begin
        md.out_ready = ($urandom_range(0, 3) != 0);
        flush        = ($urandom_range(0, 255) == 0);
      end
    end
    md.in_valid     = 1'b0;
    md.MD_Operation = 3'($urandom);
    md.Data1        = W'($urandom);
    md.Data2        = W'($urandom);
    if (!done) fail_now("accept");
  endtask

  task automatic wait_result(output logic [W-1:0] r, output logic z, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!md.out_valid && lat < 200);
    r = md.MD_result;
    z = md.ZERO;
    if (!md.out_valid) fail_now("result");
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] lit, input int exp_lat,
                        input int hold);
    logic [W-1:0] r;
    logic         z;
    int           lat;
    chk({name, " model"}, model(op, a, b), lit);
    md.out_ready = (hold == 0);
    send(op, a, b);
    wait_result(r, z, lat);
    chk({name, " result"}, r, lit);
    chk({name, " zero"}, z, lit == '0);
    chk({name, " latency"}, lat, exp_lat);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({name, " held result"}, md.MD_result, lit);
        chk({name, " held in_ready"}, md.in_ready, 0);
      end
      @(posedge clk);
      #1;
      md.out_ready = 1'b1;
      @(negedge clk);
      chk({name, " valid before release"}, md.out_valid, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk({name, " in_ready after release"}, md.in_ready, 1);
      chk({name, " valid after release"}, md.out_valid, 0);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit saw;
    rst_n           = 1'b1;
    flush           = 1'b0;
    md.in_valid     = 1'b0;
    md.MD_Operation = 3'd0;
    md.Data1        = '0;
    md.Data2        = '0;
    md.out_ready    = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset in_ready", md.in_ready, 1);
    chk("reset out_valid", md.out_valid, 0);
    chk("reset md_result", md.MD_result, 0);
    chk("reset zero", md.ZERO, 0);
    chk("reset state", W'(dbg_state), W'(IDLE));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("mul_neg",    MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    run_op("mulh_min",   MULH,   MIN,          MIN,           32'h4000_0000, 33, 0);
    run_op("mulhu_max",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    run_op("mulhsu_max", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
    run_op("div_neg",    DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33, 0);
    run_op("rem_neg",    REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33, 0);
    run_op("divu_big",   DIVU,   32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, 33, 0);
    run_op("remu_zero",  REMU,   32'd6,        32'd3,         32'd0,         33, 0);
    run_op("divu_by0",   DIVU,   32'd5,        32'd0,         32'hFFFF_FFFF, 1,  0);
    run_op("remu_by0",   REMU,   32'd5,        32'd0,         32'd5,         1,  0);
    run_op("div_ovf",    DIV,    MIN,          32'hFFFF_FFFF, MIN,           1,  0);
    run_op("rem_ovf",    REM,    MIN,          32'hFFFF_FFFF, 32'd0,         1,  0);
    run_op("bp_mulhu",   MULHU,  32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 33, 10);

    // flush during the fifth CALC cycle, with a competing in_valid
    md.out_ready = 1'b1;
    send(DIVU, 32'd1000, 32'd3);
    repeat (4) @(posedge clk);
    #1;
    flush           = 1'b1;
    md.in_valid     = 1'b1;
    md.MD_Operation = MUL;
    md.Data1        = 32'd5;
    md.Data2        = 32'd5;
    @(negedge clk);
    chk("flush cycle in_ready", md.in_ready, 0);
    @(posedge clk);
    #1;
    flush       = 1'b0;
    md.in_valid = 1'b0;
    @(negedge clk);
    chk("after flush in_ready", md.in_ready, 1);
    chk("after flush out_valid", md.out_valid, 0);
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (md.out_valid) saw = 1;
    end
    chk("flush discards result", saw, 0);

    // asynchronous reset in the middle of CALC
    @(posedge clk);
    #1;
    send(MUL, pick(), pick());
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset in_ready", md.in_ready, 1);
    chk("mid reset out_valid", md.out_valid, 0);
    chk("mid reset md_result", md.MD_result, 0);
    chk("mid reset zero", md.ZERO, 0);
    chk("mid reset state", W'(dbg_state), W'(IDLE));
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("mul_after_reset", MUL, 32'd3, 32'd4, 32'd12, 33, 0);

    // randomized traffic with random backpressure and occasional flush
    rnd_mode = 1;
    for (int i = 0; i < 150; i++) send(3'($urandom_range(0, 7)), pick(), pick());
    rnd_mode     = 0;
    flush        = 1'b0;
    md.out_ready = 1'b1;
    repeat (40) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative, parametrised multiply/divide unit implementing the RV32M operation set.
- Sits beside the combinational ALU in the execute stage. The core stalls on `in_ready`/`out_valid`.
- Uses a valid/ready handshake on both input and output, plus a synchronous flush.
- Computes one radix-2 step per cycle. Provides a ZERO flag like the base ALU.

Parameters:
- WIDTH, 32: operand and result width in bits (≥4, even).
- CNT_W, $clog2(WIDTH+1): iteration counter width (derived; not overridable).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of the in-flight operation
- in_valid  in  1  operands and op are valid
- in_ready  out  1  unit can accept an operation
- MD_Operation  in  3  RV32M funct3: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7
- Data1  in  WIDTH  rs1 operand (multiplicand / dividend)
- Data2  in  WIDTH  rs2 operand (multiplier / divisor)
- out_valid  out  1  result is valid
- out_ready  in  1  consumer accepts the result
- MD_result  out  WIDTH  result
- ZERO  out  1  MD_result == 0; qualified by out_valid

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, MD_result=0, ZERO=0 (reset value of MD_result is 0, so ZERO resets to 0 by explicit rule), counter=0.
- FSM states are IDLE, CALC and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch op, operands and sign flags.
  - If divide-by-zero or signed overflow → DONE. Otherwise → CALC with counter=WIDTH.
- CALC:
  - in_ready=0.
  - One shift-add (mul) or restoring shift-subtract (div) step per cycle on unsigned magnitudes.
  - Counter decrements each cycle. On the cycle counter reaches 1, apply sign correction, register the result, → DONE.
- DONE:
  - out_valid=1 and MD_result held stable until out_ready.
  - On out_valid&out_ready → IDLE.
  - No new accept in the same cycle; in_ready=0 in DONE.
- Latency:
  - Normal ops: out_valid rises WIDTH+1 cycles after the accept edge.
  - Special cases: out_valid rises 1 cycle after the accept edge.
  - Throughput: one op per WIDTH+2 cycles with out_ready held high.
- Multiply:
  - 2·WIDTH-bit product of magnitudes, negated if the signs differ.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - MULHSU treats Data1 signed and Data2 unsigned.
- Divide:
  - Quotient truncates toward zero. The remainder takes the sign of the dividend.
  - DIVU/REMU are unsigned.
- Special cases (RISC-V spec, no trap):
  - Divisor==0: DIV/DIVU → all ones; REM/REMU → Data1.
  - Signed overflow (Data1=1<<(WIDTH-1), Data2=all ones, DIV/REM only): DIV → Data1; REM → 0.
- Magnitude of the most-negative value is 1<<(WIDTH-1), held in an unsigned WIDTH-bit register; no extension needed.
- ZERO is combinational from the registered MD_result. It is meaningful only while out_valid=1.
- flush=1 in any state: → IDLE next edge, out_valid=0, the pending result is discarded.
  - flush has priority over in_valid and over out_ready.
  - in_valid in a flush cycle is not accepted (in_ready forced 0 that cycle).
- rst_n asserted mid-CALC or mid-DONE: immediate return to reset values; no output is produced.
- Inputs are sampled only at the accept edge. Data1/Data2 may change during CALC without effect.

Decomposition:
- Package muldiv_pkg:
  - md_op_e enum (3-bit funct3 encodings above)
  - state_e {IDLE, CALC, DONE}
  - helper functions is_signed_a(op), is_signed_b(op), is_div(op), is_high(op)
- One natural sub-module, muldiv_step: a combinational single-iteration datapath (shift-add / trial-subtract) instantiated once in the top FSM.

Test Plan:
- WIDTH=32, MUL 7×0xFFFFFFFD (−3) → MD_result=0xFFFFFFEB, out_valid exactly 33 cycles after accept, ZERO=0.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7)/2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC. REMU 6/3 → 0, ZERO=1.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, out_valid 1 cycle after accept. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, 1-cycle latency.
- Backpressure: out_ready=0 for 10 cycles in DONE → MD_result stable, in_ready=0. Raise out_ready → in_ready=1 next cycle.
- Flush at CALC cycle 5 → out_valid never rises, in_ready=1 next cycle. Then rst_n low for 1 cycle mid-CALC → all outputs at reset values immediately. A new MUL 3×4 then returns 12.
